// File: rtl/hilo_sequencer_pkg.sv
// Shared processor definitions: HI/LO operation codes, sequencer state
// encodings and the 64-bit accumulate helper used by the execute stage.
package hilo_sequencer_pkg;

    localparam int unsigned CNT_W = 4;

    typedef enum logic [2:0] {
        OP_MULT = 3'd0,
        OP_MADD = 3'd1,
        OP_MSUB = 3'd2,
        OP_MTHI = 3'd3,
        OP_MTLO = 3'd4
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ACCUM = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic logic is_mul_op(input logic [2:0] op);
        return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB);
    endfunction

    // Only MADD adds; every other latched op reaching ACCUM is MSUB.
    function automatic logic [63:0] hilo_accumulate(input op_e op,
                                                    input logic [63:0] acc,
                                                    input logic [63:0] prod);
        return (op == OP_MADD) ? acc + prod : acc - prod;
    endfunction

endpackage

// File: rtl/hilo_sequencer_latency.sv
// Loadable down-counter that times the ALU multiply latency.
module latency_counter
    import hilo_sequencer_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             dec,
    input  logic [CNT_W-1:0] load_value,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_value;
        end else if (dec && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/hilo_sequencer.sv
// HI/LO register sequencer: stalls the pipeline while a multi-cycle
// multiply settles, then loads or accumulates the product into HI/LO.
module hilo_sequencer
    import hilo_sequencer_pkg::*;
#(
    parameter int unsigned MUL_LATENCY = 4
)
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        StartIn,
    input  logic [2:0]  OpIn,
    input  logic [31:0] DataIn,
    input  logic [63:0] ALUResultIn,
    input  logic        FlushIn,
    output logic        StallOut,
    output logic        DoneOut,
    output logic [31:0] HiOut,
    output logic [31:0] LoOut
);

    localparam logic [CNT_W-1:0] LOAD_VALUE = CNT_W'(MUL_LATENCY - 1);

    state_e      state;
    state_e      state_next;
    op_e         op_q;
    logic [63:0] prod_q;
    logic [63:0] hilo_q;
    logic [63:0] hilo_d;

    logic hilo_we;
    logic hi_we;
    logic lo_we;
    logic op_load;
    logic prod_load;
    logic cnt_load;
    logic cnt_dec;
    logic cnt_zero;

    latency_counter u_latency_counter (
        .clk        (Clk),
        .reset      (Reset),
        .load       (cnt_load),
        .dec        (cnt_dec),
        .load_value (LOAD_VALUE),
        .zero       (cnt_zero)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        hilo_d     = hilo_q;
        hilo_we    = 1'b0;
        hi_we      = 1'b0;
        lo_we      = 1'b0;
        op_load    = 1'b0;
        prod_load  = 1'b0;
        cnt_load   = 1'b0;
        cnt_dec    = 1'b0;
        StallOut   = 1'b0;
        DoneOut    = 1'b0;

        unique case (state)
            ST_IDLE, ST_DONE: begin
                DoneOut    = (state == ST_DONE);
                state_next = ST_IDLE;
                if (!FlushIn && StartIn) begin
                    if (is_mul_op(OpIn)) begin
                        op_load    = 1'b1;
                        cnt_load   = 1'b1;
                        state_next = ST_WAIT;
                    end else if (OpIn == OP_MTHI) begin
                        hi_we = 1'b1;
                    end else if (OpIn == OP_MTLO) begin
                        lo_we = 1'b1;
                    end
                end
            end

            ST_WAIT: begin
                StallOut = 1'b1;
                if (FlushIn) begin
                    state_next = ST_IDLE;
                end else if (cnt_zero) begin
                    if (op_q == OP_MULT) begin
                        hilo_d     = ALUResultIn;
                        hilo_we    = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        prod_load  = 1'b1;
                        state_next = ST_ACCUM;
                    end
                end else begin
                    cnt_dec = 1'b1;
                end
            end

            ST_ACCUM: begin
                StallOut = 1'b1;
                if (FlushIn) begin
                    state_next = ST_IDLE;
                end else begin
                    hilo_d     = hilo_accumulate(op_q, hilo_q, prod_q);
                    hilo_we    = 1'b1;
                    state_next = ST_DONE;
                end
            end

            default: state_next = ST_IDLE;
        endcase
    end

    // Full 64-bit writes and the MTHI/MTLO half writes are mutually exclusive by state.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            hilo_q <= '0;
            prod_q <= '0;
            op_q   <= OP_MULT;
        end else begin
            if (op_load) begin
                op_q <= op_e'(OpIn);
            end
            if (prod_load) begin
                prod_q <= ALUResultIn;
            end
            if (hilo_we) begin
                hilo_q <= hilo_d;
            end else begin
                if (hi_we) begin
                    hilo_q[63:32] <= DataIn;
                end
                if (lo_we) begin
                    hilo_q[31:0] <= DataIn;
                end
            end
        end
    end

    assign HiOut = hilo_q[63:32];
    assign LoOut = hilo_q[31:0];

endmodule

// File: tb/tb_hilo_sequencer.sv
// Scoreboard bench for hilo_sequencer at MUL_LATENCY=4.
module tb_hilo_sequencer;

    localparam logic [2:0] T_MULT = 3'd0;
    localparam logic [2:0] T_MADD = 3'd1;
    localparam logic [2:0] T_MSUB = 3'd2;
    localparam logic [2:0] T_MTHI = 3'd3;
    localparam logic [2:0] T_MTLO = 3'd4;
    localparam logic [2:0] T_NOP  = 3'd6;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        StartIn = 1'b0;
    logic [2:0]  OpIn = '0;
    logic [31:0] DataIn = '0;
    logic [63:0] ALUResultIn = '0;
    logic        FlushIn = 1'b0;
    logic        StallOut;
    logic        DoneOut;
    logic [31:0] HiOut;
    logic [31:0] LoOut;

    int checks = 0;
    int failures = 0;
    logic [63:0] exp_q[$];
    logic [63:0] model_hilo = '0;
    logic [63:0] exp_v;

    hilo_sequencer #(.MUL_LATENCY(4)) dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .StartIn     (StartIn),
        .OpIn        (OpIn),
        .DataIn      (DataIn),
        .ALUResultIn (ALUResultIn),
        .FlushIn     (FlushIn),
        .StallOut    (StallOut),
        .DoneOut     (DoneOut),
        .HiOut       (HiOut),
        .LoOut       (LoOut)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic issue_op(input logic [2:0] op, input logic [31:0] data,
                            input logic [63:0] alu);
        StartIn     = 1'b1;
        OpIn        = op;
        DataIn      = data;
        ALUResultIn = alu;
        tick();
        StartIn = 1'b0;
        OpIn    = T_NOP;
    endtask

    // Counts stall cycles from the current sample point until DoneOut, bounded.
    task automatic wait_done(output int stalls, output bit seen);
        stalls = 0;
        seen   = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (DoneOut) begin
                seen = 1'b1;
                break;
            end
            if (StallOut) stalls++;
            tick();
        end
    endtask

    task automatic test_reset();
        Reset   = 1'b1;
        StartIn = 1'b1;
        OpIn    = T_MTHI;
        DataIn  = 32'h1234_5678;
        tick();
        tick();
        StartIn = 1'b0;
        checks++; if (StallOut !== 1'b0) begin failures++; $display("FAIL reset_stall got=%b want=0", StallOut); end
        checks++; if (DoneOut !== 1'b0) begin failures++; $display("FAIL reset_done got=%b want=0", DoneOut); end
        checks++; if (HiOut !== 32'h0) begin failures++; $display("FAIL reset_hi got=%h want=0", HiOut); end
        checks++; if (LoOut !== 32'h0) begin failures++; $display("FAIL reset_lo got=%h want=0", LoOut); end
        Reset = 1'b0;
        tick();
        model_hilo = '0;
        checks++; if ({HiOut, LoOut} !== 64'h0) begin failures++; $display("FAIL post_reset_hilo got=%h want=0", {HiOut, LoOut}); end
    endtask

    task automatic test_mult();
        int stalls; bit seen;
        model_hilo = 64'h00000001_00000002;
        exp_q.push_back(model_hilo);
        issue_op(T_MULT, 32'h0, 64'h00000001_00000002);
        wait_done(stalls, seen);
        checks++; if (!seen) begin failures++; $display("FAIL mult_done_timeout got=none want=pulse"); end
        checks++; if (stalls != 4) begin failures++; $display("FAIL mult_stall_cycles got=%0d want=4", stalls); end
        exp_v = exp_q.pop_front();
        checks++; if ({HiOut, LoOut} !== exp_v) begin failures++; $display("FAIL mult_hilo got=%h want=%h", {HiOut, LoOut}, exp_v); end
        tick();
        checks++; if (DoneOut !== 1'b0) begin failures++; $display("FAIL mult_done_single got=%b want=0", DoneOut); end
    endtask

    task automatic test_madd_carry();
        int stalls; bit seen;
        issue_op(T_MTHI, 32'h0, 64'h0);
        issue_op(T_MTLO, 32'hFFFF_FFFF, 64'h0);
        model_hilo = 64'h00000000_FFFFFFFF;
        checks++; if ({HiOut, LoOut} !== model_hilo) begin failures++; $display("FAIL mtlo_value got=%h want=%h", {HiOut, LoOut}, model_hilo); end
        exp_q.push_back(64'h00000001_00000000);
        issue_op(T_MADD, 32'h0, 64'h1);
        wait_done(stalls, seen);
        checks++; if (!seen) begin failures++; $display("FAIL madd_done_timeout got=none want=pulse"); end
        checks++; if (stalls != 5) begin failures++; $display("FAIL madd_stall_cycles got=%0d want=5", stalls); end
        exp_v = exp_q.pop_front();
        checks++; if ({HiOut, LoOut} !== exp_v) begin failures++; $display("FAIL madd_carry got=%h want=%h", {HiOut, LoOut}, exp_v); end
        model_hilo = exp_v;
        tick();
    endtask

    task automatic test_msub_wrap();
        int stalls; bit seen;
        issue_op(T_MTHI, 32'h0, 64'h0);
        issue_op(T_MTLO, 32'h0, 64'h0);
        exp_q.push_back(64'hFFFFFFFF_FFFFFFFF);
        issue_op(T_MSUB, 32'h0, 64'h1);
        wait_done(stalls, seen);
        checks++; if (!seen || stalls != 5) begin failures++; $display("FAIL msub_timing seen=%b stalls=%0d want seen=1 stalls=5", seen, stalls); end
        exp_v = exp_q.pop_front();
        checks++; if ({HiOut, LoOut} !== exp_v) begin failures++; $display("FAIL msub_wrap got=%h want=%h", {HiOut, LoOut}, exp_v); end
        model_hilo = exp_v;
        tick();
    endtask

    task automatic test_mthi();
        int bad;
        bad = 0;
        issue_op(T_MTHI, 32'hDEAD_BEEF, 64'h0);
        model_hilo[63:32] = 32'hDEAD_BEEF;
        checks++; if (HiOut !== 32'hDEAD_BEEF) begin failures++; $display("FAIL mthi_value got=%h want=deadbeef", HiOut); end
        checks++; if (LoOut !== model_hilo[31:0]) begin failures++; $display("FAIL mthi_lo_kept got=%h want=%h", LoOut, model_hilo[31:0]); end
        for (int i = 0; i < 4; i++) begin
            if (StallOut !== 1'b0 || DoneOut !== 1'b0) bad++;
            tick();
        end
        checks++; if (bad != 0) begin failures++; $display("FAIL mthi_no_stall got=%0d bad cycles want=0", bad); end
    endtask

    task automatic test_flush();
        int dones;
        dones = 0;
        issue_op(T_MULT, 32'h0, 64'h5555_5555_AAAA_AAAA);
        tick();
        checks++; if (StallOut !== 1'b1) begin failures++; $display("FAIL flush_pre_stall got=%b want=1", StallOut); end
        FlushIn = 1'b1;
        tick();
        FlushIn = 1'b0;
        checks++; if (StallOut !== 1'b0) begin failures++; $display("FAIL flush_stall_drop got=%b want=0", StallOut); end
        for (int i = 0; i < 8; i++) begin
            if (DoneOut) dones++;
            tick();
        end
        checks++; if (dones != 0) begin failures++; $display("FAIL flush_no_done got=%0d want=0", dones); end
        checks++; if ({HiOut, LoOut} !== model_hilo) begin failures++; $display("FAIL flush_hilo got=%h want=%h", {HiOut, LoOut}, model_hilo); end
    endtask

    task automatic test_flush_priority();
        FlushIn = 1'b1;
        issue_op(T_MTLO, 32'h0BAD_F00D, 64'h0);
        FlushIn = 1'b0;
        checks++; if ({HiOut, LoOut} !== model_hilo) begin failures++; $display("FAIL flush_over_start got=%h want=%h", {HiOut, LoOut}, model_hilo); end
        FlushIn = 1'b1;
        issue_op(T_MULT, 32'h0, 64'h1);
        FlushIn = 1'b0;
        checks++; if (StallOut !== 1'b0) begin failures++; $display("FAIL flush_blocks_mult got=%b want=0", StallOut); end
    endtask

    task automatic test_back_to_back();
        int stalls; bit seen;
        issue_op(T_MTHI, 32'h0, 64'h0);
        issue_op(T_MTLO, 32'h0, 64'h0);
        exp_q.push_back(64'h00000010_00000020);
        exp_q.push_back(64'h00000010_00000020 + 64'h00000003_FFFFFFF0);
        issue_op(T_MULT, 32'h0, 64'h00000010_00000020);
        wait_done(stalls, seen);
        exp_v = exp_q.pop_front();
        checks++; if (!seen || {HiOut, LoOut} !== exp_v) begin failures++; $display("FAIL b2b_first got=%h want=%h seen=%b", {HiOut, LoOut}, exp_v, seen); end
        issue_op(T_MADD, 32'h0, 64'h00000003_FFFFFFF0);
        checks++; if (StallOut !== 1'b1) begin failures++; $display("FAIL b2b_accept_in_done got=%b want=1", StallOut); end
        wait_done(stalls, seen);
        exp_v = exp_q.pop_front();
        checks++; if (!seen || stalls != 5) begin failures++; $display("FAIL b2b_second_timing seen=%b stalls=%0d want 1/5", seen, stalls); end
        checks++; if ({HiOut, LoOut} !== exp_v) begin failures++; $display("FAIL b2b_second got=%h want=%h", {HiOut, LoOut}, exp_v); end
        model_hilo = exp_v;
        tick();
    endtask

    task automatic test_reset_in_accum();
        int stalls; bit seen;
        issue_op(T_MADD, 32'h0, 64'h5);
        for (int i = 0; i < 4; i++) tick();
        checks++; if (StallOut !== 1'b1) begin failures++; $display("FAIL accum_reached got=%b want=1", StallOut); end
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        model_hilo = '0;
        checks++; if ({StallOut, DoneOut, HiOut, LoOut} !== 66'h0) begin failures++; $display("FAIL reset_accum_outputs got=%b%b %h %h want all 0", StallOut, DoneOut, HiOut, LoOut); end
        exp_q.push_back(64'h12345678_9ABCDEF0);
        issue_op(T_MULT, 32'h0, 64'h12345678_9ABCDEF0);
        wait_done(stalls, seen);
        checks++; if (!seen || stalls != 4) begin failures++; $display("FAIL post_reset_timing seen=%b stalls=%0d want 1/4", seen, stalls); end
        exp_v = exp_q.pop_front();
        checks++; if ({HiOut, LoOut} !== exp_v) begin failures++; $display("FAIL post_reset_mult got=%h want=%h", {HiOut, LoOut}, exp_v); end
        tick();
    endtask

    initial begin
        test_reset();
        test_mult();
        test_madd_carry();
        test_msub_wrap();
        test_mthi();
        test_flush();
        test_flush_priority();
        test_back_to_back();
        test_reset_in_accum();
        checks++; if (exp_q.size() != 0) begin failures++; $display("FAIL scoreboard_leftover got=%0d want=0", exp_q.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
